mem_port_arbiter: RTL and testbench

//  Shares one single-ported, variable-latency memory between the IF-stage fetch port and the MEM-stage data port.

---
 rtl/mem_port_arbiter.sv | 119 +++++++++++
 tb/tb_mem_port_arbiter.sv | 136 +++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one req/ack memory between the fetch port and the data port, with data priority, anti-starvation and a bus timeout
module mem_port_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          if_req_i,
  input  logic [AW-1:0] if_addr_i,
  output logic [DW-1:0] if_rdata_o,
  output logic          if_ready_o,
  input  logic          dm_read_i,
  input  logic          dm_write_i,
  input  logic [AW-1:0] dm_addr_i,
  input  logic [DW-1:0] dm_wdata_i,
  output logic [DW-1:0] dm_rdata_o,
  output logic          dm_ready_o,
  output logic          mem_req_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  input  logic [DW-1:0] mem_rdata_i,
  input  logic          mem_ack_i,
  output logic          stall_if_o,
  output logic          stall_mem_o,
  output logic          bus_err_o
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);
  logic [1:0]    state_q, state_d;
  logic          last_dm_q, last_dm_d;
  logic [7:0]    cnt_q, cnt_d;
  logic          port_q, port_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] if_rdata_q, if_rdata_d;
  logic [DW-1:0] dm_rdata_q, dm_rdata_d;
  logic          bus_err_q, bus_err_d;
  logic          dm_pend, grant_dm, expire;
  logic [DW-1:0] rd;
  assign dm_pend  = dm_read_i | dm_write_i;
  // the fetch port takes the turn right after a data grant so it cannot starve
  assign grant_dm = dm_pend & ~(last_dm_q & if_req_i);
  assign expire   = ~mem_ack_i & (cnt_q == CNT_LAST);
  assign rd       = mem_ack_i ? mem_rdata_i : '0;
  always_comb begin
    state_d    = state_q;
    last_dm_d  = last_dm_q;
    cnt_d      = cnt_q;
    port_d     = port_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;
    bus_err_d  = bus_err_q;
    case (state_q)
      IDLE: if (dm_pend | if_req_i) begin
        state_d   = BUSY;
        port_d    = grant_dm;
        last_dm_d = grant_dm;
        we_d      = grant_dm & dm_write_i;
        addr_d    = grant_dm ? dm_addr_i : if_addr_i;
        wdata_d   = dm_wdata_i;
        cnt_d     = '0;
      end
      BUSY: if (mem_ack_i | expire) begin
        state_d    = DONE;
        bus_err_d  = bus_err_q | expire;
        if_rdata_d = (!we_q && !port_q) ? rd : if_rdata_q;
        dm_rdata_d = (!we_q && port_q) ? rd : dm_rdata_q;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      last_dm_q  <= 1'b0;
      cnt_q      <= '0;
      port_q     <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
      bus_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_dm_q  <= last_dm_d;
      cnt_q      <= cnt_d;
      port_q     <= port_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
      bus_err_q  <= bus_err_d;
    end
  end
  // a fetch whose request was dropped or redirected gets no completion pulse
  assign if_ready_o  = (state_q == DONE) & ~port_q & if_req_i & (if_addr_i == addr_q);
  assign dm_ready_o  = (state_q == DONE) & port_q;
  assign mem_req_o   = (state_q == BUSY);
  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign if_rdata_o  = if_rdata_q;
  assign dm_rdata_o  = dm_rdata_q;
  assign bus_err_o   = bus_err_q;
  assign stall_if_o  = if_req_i & ~if_ready_o;
  assign stall_mem_o = dm_pend & ~dm_ready_o;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks of arbitration, latency, stale fetch, timeout and reset
module tb_mem_port_arbiter;
  logic        clk = 0, rst_n = 0;
  logic        if_req = 0, dm_read = 0, dm_write = 0, mem_ack = 0;
  logic [31:0] if_addr = 0, dm_addr = 0, dm_wdata = 0, mem_rdata = 0;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
  logic        if_ready, dm_ready, mem_req, mem_we, stall_if, stall_mem, bus_err;
  int          n_chk = 0, n_fail = 0;
  mem_port_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_rdata_o(if_rdata), .if_ready_o(if_ready),
    .dm_read_i(dm_read), .dm_write_i(dm_write), .dm_addr_i(dm_addr), .dm_wdata_i(dm_wdata),
    .dm_rdata_o(dm_rdata), .dm_ready_o(dm_ready),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_rdata_i(mem_rdata), .mem_ack_i(mem_ack),
    .stall_if_o(stall_if), .stall_mem_o(stall_mem), .bus_err_o(bus_err)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    logic exp_dm;
    #1;
    chk("reset_outs", {if_ready, dm_ready, mem_req, bus_err, if_rdata, dm_rdata}, '0);
    tick; tick;
    rst_n = 1;
    tick;
    // 1) fetch only, ack in first BUSY cycle
    if_req = 1; if_addr = 32'h100; #1;
    chk("t1_idle", {stall_if, mem_req, if_ready}, 3'b100);
    tick;
    mem_ack = 1; mem_rdata = 32'h11223344; #1;
    chk("t1_busy", {stall_if, mem_req, mem_we, mem_addr}, {3'b110, 32'h100});
    tick;
    mem_ack = 0; #1;
    chk("t1_done", {if_ready, stall_if, mem_req, if_rdata}, {3'b100, 32'h11223344});
    if_req = 0;
    tick;
    chk("t1_after", {if_ready, if_rdata}, {1'b0, 32'h11223344});
    // 2) both ports held: grants alternate DM, IF, DM, IF
    dm_read = 1; dm_addr = 32'h200; if_req = 1; if_addr = 32'h104; #1;
    for (int i = 0; i < 4; i++) begin
      exp_dm = (i % 2 == 0);
      tick;
      chk("t2_grant_addr", {mem_req, mem_addr}, {1'b1, exp_dm ? 32'h200 : 32'h104});
      mem_ack = 1; mem_rdata = 32'hA000 + i;
      tick;
      mem_ack = 0; #1;
      chk("t2_ready", {dm_ready, if_ready}, {exp_dm, ~exp_dm});
      chk("t2_rdata", exp_dm ? dm_rdata : if_rdata, 32'hA000 + i);
      tick;
    end
    if_req = 0; dm_read = 0; #1;
    // 3) write, ack in fifth BUSY cycle, bus stable throughout
    dm_write = 1; dm_addr = 32'h10; dm_wdata = 32'hCAFEF00D; #1;
    tick;
    for (int k = 0; k < 5; k++) begin
      chk("t3_busy_bus", {mem_req, mem_we, mem_addr, mem_wdata, dm_ready, stall_mem},
          {2'b11, 32'h10, 32'hCAFEF00D, 2'b01});
      if (k == 4) mem_ack = 1;
      tick;
    end
    mem_ack = 0; #1;
    chk("t3_done", {dm_ready, stall_mem, mem_req, dm_rdata}, {3'b100, 32'hA002});
    dm_write = 0;
    tick;
    chk("t3_single_pulse", {dm_ready, mem_req}, 2'b00);
    // 4) fetch redirected while BUSY
    if_req = 1; if_addr = 32'h40;
    tick;
    chk("t4_busy40", mem_addr, 32'h40);
    if_addr = 32'h80; #1;
    chk("t4_stall_busy", stall_if, 1'b1);
    tick;
    mem_ack = 1; mem_rdata = 32'hBAD;
    tick;
    mem_ack = 0; #1;
    chk("t4_stale_done", {if_ready, stall_if}, 2'b01);
    tick;
    chk("t4_idle", {stall_if, mem_req}, 2'b10);
    tick;
    chk("t4_busy80", {mem_req, mem_addr, stall_if}, {1'b1, 32'h80, 1'b1});
    mem_ack = 1; mem_rdata = 32'h0800D;
    tick;
    mem_ack = 0; #1;
    chk("t4_done80", {if_ready, if_rdata}, {1'b1, 32'h0800D});
    if_req = 0;
    tick;
    // 5) timeout after 255 BUSY cycles
    if_req = 1; if_addr = 32'h300; mem_rdata = 32'hFFFF;
    tick;
    repeat (254) tick;
    chk("t5_last_busy", {mem_req, bus_err, if_ready}, 3'b100);
    tick;
    chk("t5_timeout", {mem_req, bus_err, if_ready, if_rdata}, {3'b011, 32'h0});
    if_req = 0;
    tick;
    chk("t5_sticky", {bus_err, if_ready, if_rdata}, {2'b10, 32'h0});
    // 6) reset mid-BUSY
    dm_read = 1; dm_addr = 32'h500;
    tick;
    chk("t6_busy", mem_req, 1'b1);
    #2 rst_n = 0; #1;
    chk("t6_async_rst", {mem_req, dm_ready, if_ready, bus_err}, 4'b0000);
    dm_read = 0;
    tick;
    rst_n = 1;
    tick;
    chk("t6_no_ready", {dm_ready, mem_req, bus_err}, 3'b000);
    dm_read = 1; dm_addr = 32'h600;
    tick;
    chk("t6_new_busy", {mem_req, mem_addr}, {1'b1, 32'h600});
    mem_ack = 1; mem_rdata = 32'h66;
    tick;
    mem_ack = 0; #1;
    chk("t6_new_done", {dm_ready, dm_rdata, bus_err}, {1'b1, 32'h66, 1'b0});
    dm_read = 0;
    tick;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
